// File: rtl/carpma_denetleyici.sv
// Issue/retire controller for the 3-stage pipelined multiplier: credit-gated issue,
// tag/half sideband pipe aligned to the multiplier latency, and an in-order result FIFO.
module carpma_denetleyici #(
  parameter int VERI_BIT      = 32,
  parameter int GECIKME       = 3,
  parameter int FIFO_DERINLIK = 5,
  parameter int ETIKET_BIT    = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  istek_gecerli_i,
  output logic                  istek_hazir_o,
  input  logic [1:0]            istek_islem_i,
  input  logic [VERI_BIT-1:0]   istek_islec0_i,
  input  logic [VERI_BIT-1:0]   istek_islec1_i,
  input  logic [ETIKET_BIT-1:0] istek_etiket_i,
  input  logic                  iptal_i,
  output logic                  sonuc_gecerli_o,
  input  logic                  sonuc_hazir_i,
  output logic [VERI_BIT-1:0]   sonuc_o,
  output logic [ETIKET_BIT-1:0] sonuc_etiket_o,
  output logic [VERI_BIT-1:0]   carpici_islec0_o,
  output logic                  carpici_islec0_isaretli_o,
  output logic [VERI_BIT-1:0]   carpici_islec1_o,
  output logic                  carpici_islec1_isaretli_o,
  output logic                  carpici_gecerli_o,
  input  logic [2*VERI_BIT-1:0] carpici_carpim_i,
  input  logic                  carpici_gecerli_i,
  output logic                  mesgul_o,
  output logic                  hata_o
);

  typedef enum logic [1:0] {
    ISLEM_MUL    = 2'b00,
    ISLEM_MULH   = 2'b01,
    ISLEM_MULHSU = 2'b10,
    ISLEM_MULHU  = 2'b11
  } islem_t;

  typedef struct packed {
    logic                  gecerli;
    logic                  ust_yari;
    logic [ETIKET_BIT-1:0] etiket;
  } yan_t;

  typedef struct packed {
    logic [VERI_BIT-1:0]   sonuc;
    logic [ETIKET_BIT-1:0] etiket;
  } kayit_t;

  localparam int PW = (FIFO_DERINLIK > 1) ? $clog2(FIFO_DERINLIK) : 1;
  localparam int SW = $clog2(FIFO_DERINLIK + 1);
  localparam int UW = $clog2(GECIKME + 1);
  localparam int KW = $clog2(FIFO_DERINLIK + GECIKME + 1);

  islem_t          islem;
  logic            kabul;
  yan_t            yeni_yan;
  yan_t            yan_q [GECIKME];
  yan_t            son_yan;
  logic [UW-1:0]   ucusta;
  logic [KW-1:0]   kredit;

  kayit_t          bellek_q [FIFO_DERINLIK];
  kayit_t          yeni_kayit;
  logic [PW-1:0]   yaz_ptr_q;
  logic [PW-1:0]   oku_ptr_q;
  logic [SW-1:0]   sayac_q;
  logic            it;
  logic            cek;
  logic            hata_q;

  function automatic logic [PW-1:0] sonraki(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DERINLIK - 1)) ? '0 : p + PW'(1);
  endfunction

  assign islem = islem_t'(istek_islem_i);

  // Pops are deliberately not credited so ready has no path from sonuc_hazir_i.
  assign kredit        = KW'(sayac_q) + KW'(ucusta);
  assign istek_hazir_o = !rst_i && !iptal_i && (kredit < KW'(FIFO_DERINLIK));
  assign kabul         = istek_gecerli_i && istek_hazir_o;

  assign carpici_gecerli_o         = kabul;
  assign carpici_islec0_o          = istek_islec0_i;
  assign carpici_islec1_o          = istek_islec1_i;
  assign carpici_islec0_isaretli_o = (islem == ISLEM_MULH) || (islem == ISLEM_MULHSU);
  assign carpici_islec1_isaretli_o = (islem == ISLEM_MULH);

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    yeni_yan          = '0;
    yeni_yan.gecerli  = kabul;
    yeni_yan.ust_yari = (islem != ISLEM_MUL);
    yeni_yan.etiket   = istek_etiket_i;
    ucusta            = '0;
    for (int i = 0; i < GECIKME; i++) begin
      ucusta = ucusta + UW'(yan_q[i].gecerli);
    end
  end

  // NOTE: state registers use non-blocking assignments so all stages update from pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < GECIKME; i++) yan_q[i] <= '0;
    end else begin
      yan_q[0] <= yeni_yan;
      for (int i = 1; i < GECIKME; i++) yan_q[i] <= yan_q[i-1];
      if (iptal_i) begin
        for (int i = 0; i < GECIKME; i++) yan_q[i].gecerli <= 1'b0;
      end
    end
  end

  // The last sideband stage lines up with the product of the op it describes.
  assign son_yan           = yan_q[GECIKME-1];
  assign yeni_kayit.sonuc  = son_yan.ust_yari ? carpici_carpim_i[2*VERI_BIT-1:VERI_BIT]
                                              : carpici_carpim_i[VERI_BIT-1:0];
  assign yeni_kayit.etiket = son_yan.etiket;
  assign it                = son_yan.gecerli && !iptal_i && !rst_i;

  assign sonuc_gecerli_o = !rst_i && (sayac_q != '0);
  assign cek             = sonuc_gecerli_o && sonuc_hazir_i;
  assign sonuc_o         = bellek_q[oku_ptr_q].sonuc;
  assign sonuc_etiket_o  = bellek_q[oku_ptr_q].etiket;

  // NOTE: the storage array has no reset; only pointers and count qualify its contents.
  always_ff @(posedge clk_i) begin
    if (it) bellek_q[yaz_ptr_q] <= yeni_kayit;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || iptal_i) begin
      yaz_ptr_q <= '0;
      oku_ptr_q <= '0;
      sayac_q   <= '0;
    end else begin
      if (it)  yaz_ptr_q <= sonraki(yaz_ptr_q);
      if (cek) oku_ptr_q <= sonraki(oku_ptr_q);
      case ({it, cek})
        2'b10:   sayac_q <= sayac_q + SW'(1);
        2'b01:   sayac_q <= sayac_q - SW'(1);
        default: sayac_q <= sayac_q;
      endcase
    end
  end

  // Missing multiplier valid is only diagnosed; data is taken on sideband timing alone.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hata_q <= 1'b0;
    end else if (son_yan.gecerli && !carpici_gecerli_i) begin
      hata_q <= 1'b1;
    end
  end

  assign hata_o   = hata_q;
  assign mesgul_o = !rst_i && ((sayac_q != '0) || (ucusta != '0));

endmodule

// File: tb/tb_carpma_denetleyici.sv
// Self-checking bench for carpma_denetleyici with a behavioural 3-cycle multiplier
// and an ISA-level reference queue of expected results.
module tb_carpma_denetleyici;

  localparam int DERINLIK = 5;
  localparam logic [1:0] MUL = 2'b00, MULH = 2'b01, MULHSU = 2'b10, MULHU = 2'b11;

  typedef struct {
    logic [31:0] sonuc;
    logic [4:0]  etiket;
  } kayit_t;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        istek_gecerli_i;
  logic        istek_hazir_o;
  logic [1:0]  istek_islem_i;
  logic [31:0] istek_islec0_i;
  logic [31:0] istek_islec1_i;
  logic [4:0]  istek_etiket_i;
  logic        iptal_i;
  logic        sonuc_gecerli_o;
  logic        sonuc_hazir_i;
  logic [31:0] sonuc_o;
  logic [4:0]  sonuc_etiket_o;
  logic [31:0] carpici_islec0_o;
  logic        carpici_islec0_isaretli_o;
  logic [31:0] carpici_islec1_o;
  logic        carpici_islec1_isaretli_o;
  logic        carpici_gecerli_o;
  logic [63:0] carpici_carpim_i;
  logic        carpici_gecerli_i;
  logic        mesgul_o;
  logic        hata_o;

  logic        bozuk = 1'b0;
  int          n_assert = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          kabul_say = 0;
  kayit_t      model_q[$];
  kayit_t      alinan_q[$];
  int          cek_cyc_q[$];

  carpma_denetleyici dut (
    .clk_i                     (clk_i),
    .rst_i                     (rst_i),
    .istek_gecerli_i           (istek_gecerli_i),
    .istek_hazir_o             (istek_hazir_o),
    .istek_islem_i             (istek_islem_i),
    .istek_islec0_i            (istek_islec0_i),
    .istek_islec1_i            (istek_islec1_i),
    .istek_etiket_i            (istek_etiket_i),
    .iptal_i                   (iptal_i),
    .sonuc_gecerli_o           (sonuc_gecerli_o),
    .sonuc_hazir_i             (sonuc_hazir_i),
    .sonuc_o                   (sonuc_o),
    .sonuc_etiket_o            (sonuc_etiket_o),
    .carpici_islec0_o          (carpici_islec0_o),
    .carpici_islec0_isaretli_o (carpici_islec0_isaretli_o),
    .carpici_islec1_o          (carpici_islec1_o),
    .carpici_islec1_isaretli_o (carpici_islec1_isaretli_o),
    .carpici_gecerli_o         (carpici_gecerli_o),
    .carpici_carpim_i          (carpici_carpim_i),
    .carpici_gecerli_i         (carpici_gecerli_i),
    .mesgul_o                  (mesgul_o),
    .hata_o                    (hata_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Behavioural multiplier: signed/unsigned-extended 64-bit product, 3 cycles, no stall.
  function automatic logic [63:0] urun(input logic [31:0] a, b, input logic sa, sb);
    longint x, y;
    x = sa ? longint'($signed(a)) : longint'({32'b0, a});
    y = sb ? longint'($signed(b)) : longint'({32'b0, b});
    return x * y;
  endfunction

  logic [2:0]  m_v = '0;
  logic [63:0] m_p [3];
  always @(posedge clk_i) begin
    m_v    <= {m_v[1:0], carpici_gecerli_o};
    m_p[0] <= urun(carpici_islec0_o, carpici_islec1_o,
                   carpici_islec0_isaretli_o, carpici_islec1_isaretli_o);
    m_p[1] <= m_p[0];
    m_p[2] <= m_p[1];
  end
  assign carpici_carpim_i  = m_p[2];
  assign carpici_gecerli_i = m_v[2] && !bozuk;

  // RV32M semantics computed straight from the opcode.
  function automatic logic [31:0] beklenen(input logic [1:0] op, input logic [31:0] a, b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    case (op)
      MUL:     return a * b;
      MULH:    p = sa * sb;
      MULHSU:  p = sa * ub;
      default: p = ua * ub;
    endcase
    return p[63:32];
  endfunction

  task automatic check(input string tag, input logic [63:0] gozlenen, input logic [63:0] beklenen_d);
    n_assert++;
    assert (gozlenen === beklenen_d) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, gozlenen, beklenen_d, cyc);
    end
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  logic        bekleme = 1'b0;
  logic [31:0] onceki_sonuc;
  logic [4:0]  onceki_etiket;
  always @(negedge clk_i) begin
    kayit_t e;
    check("kredit_hazir", istek_hazir_o, !rst_i && !iptal_i && model_q.size() < DERINLIK);
    check("mesgul", mesgul_o, !rst_i && model_q.size() != 0);
    check("carpici_gecerli", carpici_gecerli_o, istek_gecerli_i && istek_hazir_o);
    if (bekleme && !rst_i) begin
      check("tutma_gecerli", sonuc_gecerli_o, 1);
      check("tutma_veri", sonuc_o, onceki_sonuc);
      check("tutma_etiket", sonuc_etiket_o, onceki_etiket);
    end
    bekleme       = sonuc_gecerli_o && !sonuc_hazir_i && !iptal_i && !rst_i;
    onceki_sonuc  = sonuc_o;
    onceki_etiket = sonuc_etiket_o;
    if (sonuc_gecerli_o && sonuc_hazir_i) begin
      check("sonuc_beklenen_var", model_q.size() != 0, 1);
      if (model_q.size() != 0) begin
        e = model_q.pop_front();
        check("sonuc_veri", sonuc_o, e.sonuc);
        check("sonuc_etiket", sonuc_etiket_o, e.etiket);
      end
      e.sonuc  = sonuc_o;
      e.etiket = sonuc_etiket_o;
      alinan_q.push_back(e);
      cek_cyc_q.push_back(cyc);
    end
    if (iptal_i || rst_i) model_q.delete();
    if (istek_gecerli_i && istek_hazir_o) begin
      check("islec0", carpici_islec0_o, istek_islec0_i);
      check("islec1", carpici_islec1_o, istek_islec1_i);
      check("isaretli0", carpici_islec0_isaretli_o,
            istek_islem_i == MULH || istek_islem_i == MULHSU);
      check("isaretli1", carpici_islec1_isaretli_o, istek_islem_i == MULH);
      e.sonuc  = beklenen(istek_islem_i, istek_islec0_i, istek_islec1_i);
      e.etiket = istek_etiket_i;
      model_q.push_back(e);
      kabul_say++;
    end
  end

  task automatic cevrim();
    @(posedge clk_i);
    #1;
  endtask

  task automatic ornek();
    @(negedge clk_i);
    #1;
  endtask

  task automatic istek(input logic [1:0] op, input logic [31:0] a, b, input logic [4:0] t);
    istek_gecerli_i = 1'b1;
    istek_islem_i   = op;
    istek_islec0_i  = a;
    istek_islec1_i  = b;
    istek_etiket_i  = t;
  endtask

  function automatic logic [31:0] rnd_islec();
    case ($urandom_range(0, 3))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic bosalt(input int butce);
    int n = 0;
    ornek();
    while (model_q.size() != 0 && n < butce) begin
      cevrim();
      ornek();
      n++;
    end
    check("bosalma_sure", model_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ilk;
    rst_i = 1'b1; iptal_i = 1'b0; sonuc_hazir_i = 1'b1;
    istek(MUL, 32'h1, 32'h1, 5'd0);

    // Reset: request pending but nothing accepted or visible.
    repeat (2) begin
      cevrim(); ornek();
      check("rst_istek_hazir", istek_hazir_o, 0);
      check("rst_sonuc_gecerli", sonuc_gecerli_o, 0);
      check("rst_carpici_gecerli", carpici_gecerli_o, 0);
      check("rst_mesgul", mesgul_o, 0);
    end
    cevrim(); rst_i = 1'b0; istek_gecerli_i = 1'b0;
    ornek();
    check("rst_sonrasi_hata", hata_o, 0);
    check("rst_sonrasi_hazir", istek_hazir_o, 1);

    // 1: MULHU latency, valid exactly 4 cycles after accept.
    cevrim(); alinan_q.delete();
    istek(MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3);
    ornek();
    check("t1_kabul", carpici_gecerli_o, 1);
    for (int k = 1; k <= 5; k++) begin
      cevrim(); istek_gecerli_i = 1'b0;
      ornek();
      check("t1_gecerli_zaman", sonuc_gecerli_o, k == 4);
    end
    check("t1_adet", alinan_q.size(), 1);
    if (alinan_q.size() == 1) begin
      check("t1_sonuc", alinan_q[0].sonuc, 32'hFFFF_FFFE);
      check("t1_etiket", alinan_q[0].etiket, 5'd3);
    end

    // 2: MUL / MULH / MULHSU in order.
    cevrim(); alinan_q.delete();
    istek(MUL, 32'hFFFF_FFFF, 32'h2, 5'd10);
    cevrim(); istek(MULH, 32'hFFFF_FFFF, 32'h2, 5'd11);
    cevrim(); istek(MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd12);
    cevrim(); istek_gecerli_i = 1'b0;
    bosalt(20);
    check("t2_adet", alinan_q.size(), 3);
    if (alinan_q.size() == 3) begin
      check("t2_mul", alinan_q[0].sonuc, 32'hFFFF_FFFE);
      check("t2_mulh", alinan_q[1].sonuc, 32'hFFFF_FFFF);
      check("t2_mulhsu", alinan_q[2].sonuc, 32'hFFFF_FFFF);
      check("t2_etiket0", alinan_q[0].etiket, 5'd10);
      check("t2_etiket2", alinan_q[2].etiket, 5'd12);
    end

    // 3: 8 back-to-back random requests, full throughput.
    alinan_q.delete(); cek_cyc_q.delete(); ilk = 0;
    for (int i = 0; i < 8; i++) begin
      cevrim();
      istek(2'($urandom_range(0, 3)), rnd_islec(), rnd_islec(), 5'(i));
      ornek();
      check("t3_hazir", istek_hazir_o, 1);
      if (i == 0) ilk = cyc;
    end
    cevrim(); istek_gecerli_i = 1'b0;
    bosalt(20);
    check("t3_adet", cek_cyc_q.size(), 8);
    for (int i = 0; i < cek_cyc_q.size(); i++) check("t3_ardisik", cek_cyc_q[i], ilk + 4 + i);

    // 4: consumer stalled, credit limits acceptance to the FIFO depth.
    cevrim(); sonuc_hazir_i = 1'b0; kabul_say = 0;
    for (int i = 0; i < 12; i++) begin
      istek(2'($urandom_range(0, 3)), rnd_islec(), rnd_islec(), 5'(20 + i));
      ornek();
      if (i < 11) cevrim();
    end
    check("t4_hazir_dusuk", istek_hazir_o, 0);
    check("t4_kabul_adet", kabul_say, DERINLIK);
    cevrim(); istek_gecerli_i = 1'b0; sonuc_hazir_i = 1'b1; alinan_q.delete();
    bosalt(30);
    check("t4_cikis_adet", alinan_q.size(), DERINLIK);

    // 5: flush with two in flight and one buffered.
    cevrim(); sonuc_hazir_i = 1'b0;
    istek(MUL, 32'd11, 32'd13, 5'd20);
    cevrim(); istek_gecerli_i = 1'b0;
    cevrim(); istek(MULHU, rnd_islec(), rnd_islec(), 5'd21);
    cevrim(); istek(MULH, rnd_islec(), rnd_islec(), 5'd22);
    cevrim(); istek(MUL, 32'd1, 32'd1, 5'd23); iptal_i = 1'b1;
    ornek();
    check("t5_iptal_hazir", istek_hazir_o, 0);
    check("t5_tampon_dolu", sonuc_gecerli_o, 1);
    cevrim(); iptal_i = 1'b0; istek_gecerli_i = 1'b0;
    ornek();
    check("t5_gecerli_sonra", sonuc_gecerli_o, 0);
    check("t5_mesgul_sonra", mesgul_o, 0);
    sonuc_hazir_i = 1'b1; alinan_q.delete();
    repeat (6) begin cevrim(); ornek(); end
    check("t5_olu_sonuc_yok", alinan_q.size(), 0);
    cevrim(); istek(MUL, 32'd3, 32'd5, 5'd7);
    cevrim(); istek_gecerli_i = 1'b0;
    bosalt(20);
    check("t5_sonraki_adet", alinan_q.size(), 1);
    if (alinan_q.size() == 1) check("t5_sonraki_sonuc", alinan_q[0].sonuc, 32'd15);

    // Random soak with stalls and occasional flushes.
    for (int i = 0; i < 300; i++) begin
      cevrim();
      istek(2'($urandom_range(0, 3)), rnd_islec(), rnd_islec(), 5'($urandom));
      istek_gecerli_i = ($urandom_range(0, 1) == 1);
      iptal_i         = ($urandom_range(0, 39) == 0);
      sonuc_hazir_i   = !iptal_i && ($urandom_range(0, 3) != 0);
    end
    cevrim(); istek_gecerli_i = 1'b0; iptal_i = 1'b0; sonuc_hazir_i = 1'b1;
    bosalt(40);

    // Missing multiplier valid sets the sticky error; flush keeps it.
    cevrim(); bozuk = 1'b1;
    istek(MUL, 32'd9, 32'd9, 5'd4);
    ornek();
    for (int k = 1; k <= 4; k++) begin
      cevrim(); istek_gecerli_i = 1'b0;
      ornek();
      check("hata_zaman", hata_o, k == 4);
    end
    bozuk = 1'b0;
    bosalt(10);
    cevrim(); iptal_i = 1'b1; sonuc_hazir_i = 1'b0;
    cevrim(); iptal_i = 1'b0; sonuc_hazir_i = 1'b1;
    ornek();
    check("hata_iptal_sonrasi", hata_o, 1);

    // 6: reset mid-stream.
    sonuc_hazir_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cevrim(); istek(MULHU, rnd_islec(), rnd_islec(), 5'(i));
    end
    repeat (2) begin
      cevrim(); rst_i = 1'b1;
      ornek();
      check("t6_rst_hazir", istek_hazir_o, 0);
      check("t6_rst_sonuc_gecerli", sonuc_gecerli_o, 0);
      check("t6_rst_carpici_gecerli", carpici_gecerli_o, 0);
      check("t6_rst_mesgul", mesgul_o, 0);
    end
    cevrim(); rst_i = 1'b0; istek_gecerli_i = 1'b0; sonuc_hazir_i = 1'b1;
    ornek();
    check("t6_hata_temiz", hata_o, 0);
    check("t6_gecerli_temiz", sonuc_gecerli_o, 0);
    alinan_q.delete();
    repeat (6) begin cevrim(); ornek(); end
    check("t6_eski_sonuc_yok", alinan_q.size(), 0);
    cevrim(); istek(MUL, 32'd7, 32'd6, 5'd1);
    cevrim(); istek_gecerli_i = 1'b0;
    bosalt(20);
    check("t6_adet", alinan_q.size(), 1);
    if (alinan_q.size() == 1) begin
      check("t6_sonuc", alinan_q[0].sonuc, 32'd42);
      check("t6_etiket", alinan_q[0].etiket, 5'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
